// File: rtl/ddr2_user_if.sv
// ddr2_user_if
// Bundles the DDR2 controller user port: command/address FIFO, write-data
// FIFO, read-data return path and PHY calibration status.
//   master : test engine side (drives commands and write data)
//   slave  : controller side (drives FIFO status, read data, PHY ready)
// Signals:
//   rd_wr_n  : command direction, 1 = read
//   addr     : command address
//   wdata    : write data, one 2*DATA_WIDTH beat
//   mask     : write mask
//   af_we    : address FIFO write strobe
//   df_we    : data FIFO write strobe
//   af_afull : address FIFO almost full
//   df_afull : data FIFO almost full
//   rdata    : read data beat
//   dvalid   : read beat valid
//   phy_rdy  : PHY calibrated
interface ddr2_user_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 31
);
    logic                      rd_wr_n;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [2*DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/4-1:0]   mask;
    logic                      af_we;
    logic                      df_we;
    logic                      af_afull;
    logic                      df_afull;
    logic [2*DATA_WIDTH-1:0]   rdata;
    logic                      dvalid;
    logic                      phy_rdy;

    modport master (
        output rd_wr_n, addr, wdata, mask, af_we, df_we,
        input  af_afull, df_afull, rdata, dvalid, phy_rdy
    );

    modport slave (
        input  rd_wr_n, addr, wdata, mask, af_we, df_we,
        output af_afull, df_afull, rdata, dvalid, phy_rdy
    );
endinterface

// File: rtl/ddr2_pattern_tester.sv
// ddr2_pattern_tester
// DDR2 memory test engine on the controller user port. Writes a selectable
// pattern over a range of bursts (one command + two data beats each), reads
// the range back and checks every returned beat.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start_i      : start pulse (held pending until the PHY is ready)
//   mode_i       : pattern select (0 counter, 1 walking one, 2 LFSR,
//                  3 burst address + beat parity), sampled at start
//   base_i       : first burst address, sampled at start
//   len_i        : number of bursts, sampled at start
//   busy_o       : test running
//   done_o       : sticky test-complete flag, cleared by the next start
//   fault_o      : at least one mismatching beat
//   err_cnt_o    : saturating count of mismatching beats
//   fail_addr_o  : burst address of the first mismatch
//   errinj_i     : (DDR2_TESTER_ERRINJ_EN only) arms a one-shot that
//                  inverts bit 0 of the next written beat
//   ddr          : DDR2 user port, master side
// Optional feature macro: DDR2_TESTER_ERRINJ_EN
module ddr2_pattern_tester #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 31,
    parameter int BURST_STEP    = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [1:0]               mode_i,
    input  logic [ADDR_WIDTH-1:0]    base_i,
    input  logic [ADDR_WIDTH-1:0]    len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     fault_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic [ADDR_WIDTH-1:0]    fail_addr_o,
`ifdef DDR2_TESTER_ERRINJ_EN
    input  logic                     errinj_i,
`endif
    ddr2_user_if.master              ddr
);

    // Beat counters need one extra bit: a range of len bursts has 2*len beats.
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_ISSUE, RD_DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic                     pending_q, pending_d;
    logic [1:0]               mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [ADDR_WIDTH-1:0]    len_q, len_d;
    logic [ADDR_WIDTH-1:0]    k_q, k_d;
    logic [ADDR_WIDTH-1:0]    cmd_addr_q, cmd_addr_d;
    logic [CNT_W-1:0]         wr_beat_q, wr_beat_d;
    logic [31:0]              wr_lfsr_q, wr_lfsr_d;
    logic [CNT_W-1:0]         rx_cnt_q, rx_cnt_d;
    logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
    logic [31:0]              rd_lfsr_q, rd_lfsr_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]    fail_addr_q, fail_addr_d;
    logic                     done_q, done_d;
`ifdef DDR2_TESTER_ERRINJ_EN
    logic                     errinj_q, errinj_d;
`endif

    logic                     wr_en;
    logic                     rd_check;
    logic [2*DATA_WIDTH-1:0]  exp_beat;

    // Fibonacci LFSR, taps 32,22,2,1, shifting towards the MSB.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pattern_word(
        input logic [1:0]            mode,
        input logic [CNT_W-1:0]      n,
        input logic [31:0]           lfsr,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        case (mode)
            2'd0: w = DATA_WIDTH'(n);
            2'd1: w = DATA_WIDTH'(1) << (n % DATA_WIDTH);
            2'd2: for (int i = 0; i < DATA_WIDTH; i++) w[i] = lfsr[i % 32];
            default: begin
                w = DATA_WIDTH'(addr);
                w[DATA_WIDTH-1] = n[0];
            end
        endcase
        return w;
    endfunction

    assign wr_en    = !ddr.af_afull && !ddr.df_afull;
    assign rd_check = ((state_q == RD_ISSUE) || (state_q == RD_DRAIN)) && ddr.dvalid;
    assign exp_beat = {2{pattern_word(mode_q, rx_cnt_q, rd_lfsr_q, rd_addr_q)}};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            mode_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            k_q         <= '0;
            cmd_addr_q  <= '0;
            wr_beat_q   <= '0;
            wr_lfsr_q   <= 32'h1;
            rx_cnt_q    <= '0;
            rd_addr_q   <= '0;
            rd_lfsr_q   <= 32'h1;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            done_q      <= 1'b0;
`ifdef DDR2_TESTER_ERRINJ_EN
            errinj_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            len_q       <= len_d;
            k_q         <= k_d;
            cmd_addr_q  <= cmd_addr_d;
            wr_beat_q   <= wr_beat_d;
            wr_lfsr_q   <= wr_lfsr_d;
            rx_cnt_q    <= rx_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_lfsr_q   <= rd_lfsr_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            done_q      <= done_d;
`ifdef DDR2_TESTER_ERRINJ_EN
            errinj_q    <= errinj_d;
`endif
        end
    end

    // Next-state logic: sequencing through write and read passes, plus the
    // read-back checker, which runs independently of command issue.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        mode_d      = mode_q;
        base_d      = base_q;
        len_d       = len_q;
        k_d         = k_q;
        cmd_addr_d  = cmd_addr_q;
        wr_beat_d   = wr_beat_q;
        wr_lfsr_d   = wr_lfsr_q;
        rx_cnt_d    = rx_cnt_q;
        rd_addr_d   = rd_addr_q;
        rd_lfsr_d   = rd_lfsr_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        done_d      = done_q;
`ifdef DDR2_TESTER_ERRINJ_EN
        errinj_d    = errinj_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) pending_d = 1'b1;
                if (pending_q && ddr.phy_rdy) begin
                    pending_d   = 1'b0;
                    mode_d      = mode_i;
                    base_d      = base_i;
                    len_d       = len_i;
                    k_d         = '0;
                    cmd_addr_d  = base_i;
                    wr_beat_d   = '0;
                    wr_lfsr_d   = 32'h1;
                    rx_cnt_d    = '0;
                    rd_addr_d   = base_i;
                    rd_lfsr_d   = 32'h1;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    done_d      = 1'b0;
                    state_d     = (len_i == '0) ? DONE : WR_A;
                end
            end
            WR_A: begin
                if (wr_en) begin
                    wr_beat_d = wr_beat_q + CNT_W'(1);
                    wr_lfsr_d = lfsr_next(wr_lfsr_q);
                    state_d   = WR_B;
                end
            end
            WR_B: begin
                // The second beat belongs to an already accepted burst, so
                // it goes out regardless of FIFO status.
                wr_beat_d = wr_beat_q + CNT_W'(1);
                wr_lfsr_d = lfsr_next(wr_lfsr_q);
                if (k_q == len_q - ADDR_WIDTH'(1)) begin
                    k_d        = '0;
                    cmd_addr_d = base_q;
                    state_d    = RD_ISSUE;
                end else begin
                    k_d        = k_q + ADDR_WIDTH'(1);
                    cmd_addr_d = cmd_addr_q + ADDR_WIDTH'(BURST_STEP);
                    state_d    = WR_A;
                end
            end
            RD_ISSUE: begin
                if (!ddr.af_afull) begin
                    if (k_q == len_q - ADDR_WIDTH'(1)) begin
                        state_d = RD_DRAIN;
                    end else begin
                        k_d        = k_q + ADDR_WIDTH'(1);
                        cmd_addr_d = cmd_addr_q + ADDR_WIDTH'(BURST_STEP);
                    end
                end
            end
            RD_DRAIN: begin
                if (rx_cnt_q == {len_q, 1'b0}) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rd_check) begin
            rx_cnt_d  = rx_cnt_q + CNT_W'(1);
            rd_lfsr_d = lfsr_next(rd_lfsr_q);
            // The checked burst address moves on after the odd beat.
            if (rx_cnt_q[0]) rd_addr_d = rd_addr_q + ADDR_WIDTH'(BURST_STEP);
            if (ddr.rdata != exp_beat) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                if (err_cnt_q == '0) fail_addr_d = rd_addr_q;
            end
        end

`ifdef DDR2_TESTER_ERRINJ_EN
        // Consume before arming so a pulse coinciding with a beat affects
        // the following beat rather than being lost.
        if ((state_q == WR_A && wr_en) || state_q == WR_B) errinj_d = 1'b0;
        if (errinj_i) errinj_d = 1'b1;
`endif
    end

    // Output decode. Strobes are suppressed while reset is asserted so an
    // aborted test cannot push anything more into the controller FIFOs.
    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = done_q;
        fault_o     = (err_cnt_q != '0);
        err_cnt_o   = err_cnt_q;
        fail_addr_o = fail_addr_q;
        ddr.rd_wr_n = 1'b1;
        ddr.af_we   = 1'b0;
        ddr.df_we   = 1'b0;
        ddr.addr    = cmd_addr_q;
        ddr.mask    = '1;
        ddr.wdata   = {2{pattern_word(mode_q, wr_beat_q, wr_lfsr_q, cmd_addr_q)}};
`ifdef DDR2_TESTER_ERRINJ_EN
        ddr.wdata[0] = ddr.wdata[0] ^ errinj_q;
`endif

        case (state_q)
            WR_A: begin
                ddr.rd_wr_n = 1'b0;
                if (wr_en) begin
                    ddr.af_we = 1'b1;
                    ddr.df_we = 1'b1;
                end
            end
            WR_B: begin
                ddr.rd_wr_n = 1'b0;
                ddr.df_we   = 1'b1;
            end
            RD_ISSUE: begin
                if (!ddr.af_afull) ddr.af_we = 1'b1;
            end
            default: ;
        endcase

        if (reset) begin
            ddr.rd_wr_n = 1'b1;
            ddr.af_we   = 1'b0;
            ddr.df_we   = 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr2_pattern_tester.sv
module tb_ddr2_pattern_tester;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [30:0] base_i;
    logic [30:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        fault_o;
    logic [15:0] err_cnt_o;
    logic [30:0] fail_addr_o;
`ifdef DDR2_TESTER_ERRINJ_EN
    logic        errinj_i;
`endif

    ddr2_user_if #(.DATA_WIDTH(64), .ADDR_WIDTH(31)) ddr();

    ddr2_pattern_tester #(
        .DATA_WIDTH(64), .ADDR_WIDTH(31), .BURST_STEP(4), .ERR_CNT_WIDTH(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .base_i      (base_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fault_o     (fault_o),
        .err_cnt_o   (err_cnt_o),
        .fail_addr_o (fail_addr_o),
`ifdef DDR2_TESTER_ERRINJ_EN
        .errinj_i    (errinj_i),
`endif
        .ddr         (ddr.master)
    );

    always #5 clk = ~clk;

    // Bench state
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          cur_mode;
    logic [30:0] cur_base;
    int          corrupt_beat = -1;

    // Monitor / memory model state (written only by the monitor process)
    int          mon_wr_cmds, mon_wr_beats, mon_rd_cmds, mon_rd_beats;
    int          mon_addr_err, mon_data_err;
    logic [30:0] mon_last_wr_addr, cur_wr_addr;
    logic [127:0] mem [logic [31:0]];
    logic [30:0] rdq [$];
    int          rdt [$];
    bit          resp_half;

    typedef struct {
        int          mode;
        logic [30:0] base;
        int          len;
        int          corrupt;
        int          exp_err;
        logic [30:0] exp_fail;
        logic [30:0] exp_last_wr;
    } vec_t;

    vec_t vecs [5];

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [127:0] model_beat(input int mode, input int n, input logic [30:0] addr);
        logic [63:0] w;
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < n; i++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        case (mode)
            0: w = 64'(n);
            1: w = 64'h1 << (n % 64);
            2: w = {s, s};
            default: begin
                w = {33'b0, addr};
                w[63] = n[0];
            end
        endcase
        return {w, w};
    endfunction

    function automatic logic [30:0] burst_addr(input int k);
        return cur_base + 31'(k * 4);
    endfunction

    // Monitor and DDR controller model: records write traffic into a memory,
    // returns two beats per read command a few cycles later.
    always @(negedge clk) begin
        logic [127:0] d;
        if (reset || (start_i && !busy_o)) begin
            mon_wr_cmds = 0; mon_wr_beats = 0; mon_rd_cmds = 0; mon_rd_beats = 0;
            mon_addr_err = 0; mon_data_err = 0; mon_last_wr_addr = '0; cur_wr_addr = '0;
            mem.delete(); rdq.delete(); rdt.delete(); resp_half = 1'b0;
            ddr.dvalid = 1'b0;
        end else begin
            if (ddr.af_we && !ddr.rd_wr_n) begin
                if (ddr.addr !== burst_addr(mon_wr_cmds)) mon_addr_err++;
                cur_wr_addr = ddr.addr;
                mon_last_wr_addr = ddr.addr;
                mon_wr_cmds++;
            end
            if (ddr.df_we) begin
                if (ddr.wdata !== model_beat(cur_mode, mon_wr_beats, burst_addr(mon_wr_beats / 2)))
                    mon_data_err++;
                mem[{cur_wr_addr, mon_wr_beats[0]}] = ddr.wdata;
                mon_wr_beats++;
            end
            if (ddr.af_we && ddr.rd_wr_n) begin
                if (ddr.addr !== burst_addr(mon_rd_cmds)) mon_addr_err++;
                rdq.push_back(ddr.addr);
                rdt.push_back(cycle);
                mon_rd_cmds++;
            end
            ddr.dvalid = 1'b0;
            if (rdq.size() > 0 && cycle >= rdt[0] + 3) begin
                d = mem.exists({rdq[0], resp_half}) ? mem[{rdq[0], resp_half}] : '0;
                if (mon_rd_beats == corrupt_beat) d[0] = ~d[0];
                ddr.rdata  = d;
                ddr.dvalid = 1'b1;
                mon_rd_beats++;
                if (resp_half) begin
                    void'(rdq.pop_front());
                    void'(rdt.pop_front());
                end
                resp_half = ~resp_half;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int mode, input logic [30:0] base, input int len);
        cur_mode = mode;
        cur_base = base;
        @(posedge clk); #1;
        mode_i  = 2'(mode);
        base_i  = base;
        len_i   = 31'(len);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen_busy = 0;
        bit seen_done = 0;
        for (int i = 0; i < 50 && !seen_busy; i++) begin
            @(negedge clk);
            if (busy_o) seen_busy = 1;
        end
        for (int i = 0; i < 3000 && seen_busy && !seen_done; i++) begin
            @(negedge clk);
            if (done_o && !busy_o) seen_done = 1;
        end
        checkOutput({name, "_completed"}, 64'(seen_done), 64'd1);
    endtask

    task automatic checkResult(input string name, input int len, input int exp_err,
                               input logic [30:0] exp_fail);
        checkOutput({name, "_wr_cmds"},  64'(mon_wr_cmds),  64'(len));
        checkOutput({name, "_wr_beats"}, 64'(mon_wr_beats), 64'(2 * len));
        checkOutput({name, "_rd_cmds"},  64'(mon_rd_cmds),  64'(len));
        checkOutput({name, "_addr_err"}, 64'(mon_addr_err), 64'd0);
        checkOutput({name, "_done"},     64'(done_o),       64'd1);
        checkOutput({name, "_busy"},     64'(busy_o),       64'd0);
        checkOutput({name, "_err_cnt"},  64'(err_cnt_o),    64'(exp_err));
        checkOutput({name, "_fault"},    64'(fault_o),      64'(exp_err != 0));
        checkOutput({name, "_fail_addr"}, 64'(fail_addr_o), 64'(exp_fail));
    endtask

    initial begin
        int strobes;
        int busy_cycles;
        bit hit;

        vecs[0] = '{mode: 0, base: 31'h0,        len: 4, corrupt: -1, exp_err: 0, exp_fail: 31'h0,    exp_last_wr: 31'hC};
        vecs[1] = '{mode: 1, base: 31'h40,       len: 2, corrupt: 3,  exp_err: 1, exp_fail: 31'h44,   exp_last_wr: 31'h44};
        vecs[2] = '{mode: 2, base: 31'h1000,     len: 3, corrupt: 0,  exp_err: 1, exp_fail: 31'h1000, exp_last_wr: 31'h1008};
        vecs[3] = '{mode: 3, base: 31'h7FFFFFFC, len: 2, corrupt: -1, exp_err: 0, exp_fail: 31'h0,    exp_last_wr: 31'h0};
        vecs[4] = '{mode: 3, base: 31'h200,      len: 3, corrupt: 5,  exp_err: 1, exp_fail: 31'h208,  exp_last_wr: 31'h208};

        reset = 1'b1; start_i = 1'b0; mode_i = '0; base_i = '0; len_i = '0;
        ddr.af_afull = 1'b0; ddr.df_afull = 1'b0; ddr.phy_rdy = 1'b1; ddr.rdata = '0;
`ifdef DDR2_TESTER_ERRINJ_EN
        errinj_i = 1'b0;
`endif
        cur_mode = 0; cur_base = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy",    64'(busy_o),      64'd0);
        checkOutput("rst_done",    64'(done_o),      64'd0);
        checkOutput("rst_fault",   64'(fault_o),     64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt_o),   64'd0);
        checkOutput("rst_fail",    64'(fail_addr_o), 64'd0);
        checkOutput("rst_rd_wr_n", 64'(ddr.rd_wr_n), 64'd1);
        checkOutput("rst_mask",    64'(ddr.mask),    64'hFFFF);
        checkOutput("rst_af_we",   64'(ddr.af_we),   64'd0);
        checkOutput("rst_df_we",   64'(ddr.df_we),   64'd0);
        checkOutput("rst_addr",    64'(ddr.addr),    64'd0);
        checkOutput("rst_data",    ddr.wdata[63:0],  64'd0);
        reset = 1'b0;
        @(posedge clk);

        // Table-driven full passes
        for (int v = 0; v < 5; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            corrupt_beat = vecs[v].corrupt;
            applyStimulus(vecs[v].mode, vecs[v].base, vecs[v].len);
            waitDone(nm);
            checkResult(nm, vecs[v].len, vecs[v].exp_err, vecs[v].exp_fail);
            checkOutput({nm, "_data_err"}, 64'(mon_data_err), 64'd0);
            checkOutput({nm, "_last_wr"},  64'(mon_last_wr_addr), 64'(vecs[v].exp_last_wr));
        end
        corrupt_beat = -1;

        // len = 0: done without any strobes
        applyStimulus(0, 31'h80, 0);
        waitDone("len0");
        checkOutput("len0_wr_cmds", 64'(mon_wr_cmds), 64'd0);
        checkOutput("len0_rd_cmds", 64'(mon_rd_cmds), 64'd0);
        checkOutput("len0_done",    64'(done_o),      64'd1);

        // Flow control: address FIFO full for 5 cycles while in WR_A
        applyStimulus(0, 31'h100, 4);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (ddr.df_we && !ddr.af_we) hit = 1;
        end
        checkOutput("flow_reached_wr_b", 64'(hit), 64'd1);
        @(posedge clk); #1;
        ddr.af_afull = 1'b1;
        strobes = 0;
        repeat (5) begin
            @(negedge clk);
            if (ddr.af_we || ddr.df_we) strobes++;
        end
        @(posedge clk); #1;
        ddr.af_afull = 1'b0;
        checkOutput("flow_strobes_while_full", 64'(strobes), 64'd0);
        waitDone("flow");
        checkResult("flow", 4, 0, 31'h0);
        checkOutput("flow_data_err", 64'(mon_data_err), 64'd0);

        // Start gating on PHY ready
        @(posedge clk); #1;
        ddr.phy_rdy = 1'b0;
        applyStimulus(1, 31'h20, 2);
        busy_cycles = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_o) busy_cycles++;
        end
        checkOutput("gate_busy_while_not_rdy", 64'(busy_cycles), 64'd0);
        @(posedge clk); #1;
        ddr.phy_rdy = 1'b1;
        @(negedge clk);
        checkOutput("gate_busy_rdy_cycle", 64'(busy_o), 64'd0);
        @(negedge clk);
        checkOutput("gate_busy_next_cycle", 64'(busy_o), 64'd1);
        waitDone("gate");
        checkResult("gate", 2, 0, 31'h0);

        // Reset while in WR_B
        applyStimulus(0, 31'h0, 4);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (ddr.df_we && !ddr.af_we) hit = 1;
        end
        checkOutput("rstmid_reached_wr_b", 64'(hit), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rstmid_df_we_gated", 64'(ddr.df_we), 64'd0);
        @(posedge clk); #1;
        checkOutput("rstmid_busy",    64'(busy_o),      64'd0);
        checkOutput("rstmid_done",    64'(done_o),      64'd0);
        checkOutput("rstmid_af_we",   64'(ddr.af_we),   64'd0);
        checkOutput("rstmid_df_we",   64'(ddr.df_we),   64'd0);
        checkOutput("rstmid_rd_wr_n", 64'(ddr.rd_wr_n), 64'd1);
        checkOutput("rstmid_addr",    64'(ddr.addr),    64'd0);
        checkOutput("rstmid_err_cnt", 64'(err_cnt_o),   64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);

`ifdef DDR2_TESTER_ERRINJ_EN
        // Error injection: one inverted write beat gives exactly one error
        @(posedge clk); #1;
        errinj_i = 1'b1;
        @(posedge clk); #1;
        errinj_i = 1'b0;
        applyStimulus(2, 31'h300, 8);
        waitDone("errinj");
        checkResult("errinj", 8, 1, 31'h300);
        checkOutput("errinj_data_err", 64'(mon_data_err), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr2_pattern_tester.md
Name: ddr2_pattern_tester

Overview:
- Parametrised DDR2 memory test engine that sits on the DDR2 controller user port, in place of the fixed-size counter harness.
- Writes a selectable data pattern over a programmable burst range, reads the range back and checks every beat.
- Reports done, fault, a saturating error count and the first failing burst address.
- Control and status are plain ports; a wishbone register wrapper instantiates this block.

Parameters:
DATA_WIDTH, 64, half-beat width; the DDR user data bus is 2*DATA_WIDTH
ADDR_WIDTH, 31, DDR address width
BURST_STEP, 4, address increment per burst
ERR_CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start_i  in  1  start pulse
mode_i  in  2  pattern select, sampled at start
base_i  in  ADDR_WIDTH  first burst address, sampled at start
len_i  in  ADDR_WIDTH  number of bursts, sampled at start
busy_o  out  1  test running
done_o  out  1  sticky: test complete
fault_o  out  1  err_cnt_o != 0
err_cnt_o  out  ERR_CNT_WIDTH  mismatching beats, saturating
fail_addr_o  out  ADDR_WIDTH  address of the first failing burst
ddr_rd_wr_n_o  out  1  1 = read
ddr_addr_o  out  ADDR_WIDTH  command address
ddr_data_o  out  2*DATA_WIDTH  write data
ddr_mask_o  out  DATA_WIDTH/4  write mask, tied to all ones
ddr_af_we_o  out  1  address FIFO write
ddr_df_we_o  out  1  data FIFO write
ddr_af_afull_i  in  1  address FIFO almost full
ddr_df_afull_i  in  1  data FIFO almost full
ddr_data_i  in  2*DATA_WIDTH  read data
ddr_dvalid_i  in  1  read beat valid
ddr_phy_rdy_i  in  1  PHY calibrated

Behaviour:
- Reset values: all outputs 0 except ddr_rd_wr_n_o=1 and ddr_mask_o all ones; state IDLE; counters 0. Reset mid-test aborts the test immediately, with no further FIFO writes.
- Burst structure: one burst is one command plus two data beats. A beat is one 2*DATA_WIDTH word; a burst is two beats.
- Burst address: base + k*BURST_STEP for burst k = 0..len-1, modulo 2^ADDR_WIDTH (wraps silently).
- State IDLE:
  - A start_i pulse sets a pending flag.
  - With pending set and ddr_phy_rdy_i=1, the block latches mode, base and len, clears done_o, err_cnt_o and fail_addr_o, and moves to WR_A.
  - If len=0, it goes to DONE instead.
  - start_i while busy is ignored.
- State WR_A:
  - Enabled only when !ddr_af_afull_i && !ddr_df_afull_i; otherwise the block holds with no strobes.
  - When enabled: af_we=1, df_we=1, rd_wr_n=0, data = beat 2k, then go to WR_B.
- State WR_B: df_we=1, data = beat 2k+1, ignores afull. Then k++ and go to WR_A, or to RD_ISSUE with k reset to 0 when k = len-1.
- State RD_ISSUE: each cycle with !ddr_af_afull_i asserts af_we=1, rd_wr_n=1, addr of burst k, then k++. After burst len-1 is issued, go to RD_DRAIN.
- Read check (active in RD_ISSUE and RD_DRAIN):
  - Each ddr_dvalid_i cycle is one beat.
  - An expected-pattern generator advances once per beat.
  - A mismatch increments err_cnt_o, saturating at all ones.
  - On the first mismatch, fail_addr_o = address of burst (beat_idx>>1).
  - dvalid in any other state is ignored.
- State RD_DRAIN: when the received beat count reaches 2*len, go to DONE. There is no timeout.
- State DONE: one cycle; sets done_o, then returns to IDLE. done_o holds until the next accepted start.
- busy_o = 1 in every state except IDLE.
- First FIFO strobe appears no earlier than 1 cycle after start is accepted.
- Patterns: each is a DATA_WIDTH word replicated twice; n is the beat index from 0, independently generated for write and read.
  - mode 0: counter n.
  - mode 1: walking one, bit (n mod DATA_WIDTH) set.
  - mode 2: 32-bit LFSR, taps 32,22,2,1, seed 32'h1, advanced per beat, replicated to DATA_WIDTH.
  - mode 3: burst address in the low bits, beat parity in bit DATA_WIDTH-1.

Optional Feature:
- Macro: DDR2_TESTER_ERRINJ_EN.
- Defined: adds input port errinj_i. A pulse arms a one-shot that inverts bit 0 of the next written beat, so exactly one readback error results.
- Undefined: the port is absent and write data is always the pure pattern.

Test Plan:
- Write pass, mode 0, base=0, len=4, afull low -> 8 df_we beats (data 0..7 replicated) and 4 af_we writes (addr 0,4,8,12); then 4 read commands; 8 matching beats -> done_o=1, err_cnt_o=0.
- Flow control: ddr_af_afull_i held high 5 cycles during writes -> no strobes while high; the write sequence resumes intact and the total beat count is unchanged.
- Read corruption: mode 1, len=2, model corrupts beat 3 -> err_cnt_o=1, fail_addr_o=base+4, fault_o=1.
- Boundary: base=2^31-4, len=2 -> burst addresses 0x7FFFFFFC then 0x0. Separately, len=0 -> done_o set with no strobes.
- Start gating: start_i with phy_rdy low stays pending and the test begins 1 cycle after phy_rdy rises. Reset mid-WR_B -> all outputs return to reset values on the next cycle.
- Error injection, with DDR2_TESTER_ERRINJ_EN defined: errinj_i pulse, mode 2, len=8 -> err_cnt_o=1 exactly.
